// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and counter helper for the direct-mapped
// write-back cache controller.
package cache_pkg;

  localparam int TAG_W     = 26;
  localparam int IDX_W     = 3;
  localparam int DATA_W    = 32;
  localparam int NUM_LINES = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Eight-line tag/data/valid/dirty storage with a per-field write port and a
// combinational read port. Only valid and dirty are cleared by reset.
module cache_line_store
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic              we_tag,
  input  logic              we_data,
  input  logic              we_valid,
  input  logic              we_dirty,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_dirty
);

  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]    data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  always_ff @(negedge clk) begin
    if (we_tag)  tag_mem[wr_idx]  <= wr_tag;
    if (we_data) data_mem[wr_idx] <= wr_data;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (we_valid) valid_q[wr_idx] <= wr_valid;
      if (we_dirty) dirty_q[wr_idx] <= wr_dirty;
    end
  end

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller (8 x 32-bit lines).
// All state advances on the falling edge of clk.
module cache_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  // Handshake: a request is taken on a falling edge where req_valid && req_ready;
  // req_* are then ignored until the FSM is back in IDLE. mem_req/mem_we/mem_addr/
  // mem_wdata hold steady until a falling edge that samples mem_ack high.
  state_t state, state_nxt;
  logic   init_done;

  logic              cap_write;
  logic [TAG_W-1:0]  cap_tag;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_wdata;
  logic              was_miss;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;
  logic              line_valid, line_dirty;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid, wr_dirty;
  logic              we_tag, we_data, we_valid, we_dirty;

  logic accept, hit;
  logic unused_addr_bits;

  assign unused_addr_bits = ^req_addr[2:0];
  assign req_ready  = (state == IDLE) && init_done;
  assign accept     = req_valid && req_ready;
  assign hit        = line_valid && (line_tag == cap_tag);
  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;

  cache_line_store u_store (
    .clk      (clk),
    .reset    (reset),
    .wr_idx   (cap_idx),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .we_tag   (we_tag),
    .we_data  (we_data),
    .we_valid (we_valid),
    .we_dirty (we_dirty),
    .rd_idx   (cap_idx),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty)
  );

  // init_done keeps req_ready low until the first falling edge after reset release.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= 1'b1;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cap_write <= 1'b0;
      cap_tag   <= '0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_write <= req_write;
      cap_tag   <= req_addr[31:6];
      cap_idx   <= req_addr[5:3];
      cap_wdata <= req_wdata;
    end
  end

  // was_miss marks a request that has already been counted as a miss, so the
  // hit after the line fill is not counted as a hit.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      was_miss <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      was_miss <= 1'b0;
    end else if (state == COMPARE) begin
      if (hit && !was_miss) hit_cnt <= sat_inc(hit_cnt);
      if (!hit && !was_miss) begin
        miss_cnt <= sat_inc(miss_cnt);
        was_miss <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_tag     = cap_tag;
    wr_data    = cap_wdata;
    wr_valid   = 1'b1;
    wr_dirty   = 1'b1;
    we_tag     = 1'b0;
    we_data    = 1'b0;
    we_valid   = 1'b0;
    we_dirty   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          resp_valid = 1'b1;
          state_nxt  = IDLE;
          if (cap_write) begin
            we_data  = 1'b1;
            we_dirty = 1'b1;
          end else begin
            resp_rdata = line_data;
          end
        end else if (line_valid && line_dirty) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_tag, cap_idx, 3'b000};
        mem_wdata = line_data;
        if (mem_ack) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {cap_tag, cap_idx, 3'b000};
        if (mem_ack) begin
          wr_data   = mem_rdata;
          wr_dirty  = 1'b0;
          we_tag    = 1'b1;
          we_data   = 1'b1;
          we_valid  = 1'b1;
          we_dirty  = 1'b1;
          state_nxt = COMPARE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus random
// traffic checked against an array-based cache model and an expected-response queue.
module tb_cache_controller;
  import cache_pkg::*;

  logic        clk, reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] hit_count, miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NUM_LINES-1:0] m_valid, m_dirty;
  logic [TAG_W-1:0]     m_tag  [NUM_LINES];
  logic [DATA_W-1:0]    m_data [NUM_LINES];
  int unsigned          m_hits, m_misses;
  logic [31:0]          exp_q[$];

  cache_controller dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // Clock and reset: DUT acts on falling edges; the bench drives and samples on rising edges.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat16(input int unsigned v);
    return (v > 32'd65535) ? 32'd65535 : v;
  endfunction

  task automatic model_reset();
    m_valid  = '0;
    m_dirty  = '0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Serves one memory transfer: the current rising edge must already show the request.
  task automatic serve_mem(input string name, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int dly, input logic [31:0] rd);
    check_eq({name, "_mem_req"}, mem_req, 1'b1);
    check_eq({name, "_mem_we"}, mem_we, we);
    check_eq({name, "_mem_addr"}, mem_addr, addr);
    if (we) check_eq({name, "_mem_wdata"}, mem_wdata, wdata);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk);
      check_eq({name, "_hold_req"}, mem_req, 1'b1);
      check_eq({name, "_hold_addr"}, mem_addr, addr);
      if (we) check_eq({name, "_hold_wdata"}, mem_wdata, wdata);
      check_eq({name, "_hold_noresp"}, resp_valid, 1'b0);
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    @(posedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] fill, input int dly);
    int n;
    logic [2:0]       idx;
    logic [TAG_W-1:0] tg;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk);
      n++;
    end
    check_eq("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    idx = addr[5:3];
    tg  = addr[31:6];
    if (m_valid[idx] && m_tag[idx] == tg) begin
      m_hits++;
    end else begin
      m_misses++;
      check_eq("miss_no_resp", resp_valid, 1'b0);
      check_eq("miss_cmp_mem_req", mem_req, 1'b0);
      check_eq("miss_not_ready", req_ready, 1'b0);
      @(posedge clk);
      if (m_valid[idx] && m_dirty[idx])
        serve_mem("wb", 1'b1, {m_tag[idx], idx, 3'b000}, m_data[idx], dly, $urandom);
      serve_mem("fill", 1'b0, {tg, idx, 3'b000}, 32'h0, dly, fill);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = fill;
    end
    exp_q.push_back(wr ? 32'h0 : m_data[idx]);
    if (wr) begin
      m_data[idx]  = wdata;
      m_dirty[idx] = 1'b1;
    end
    check_eq("resp_valid", resp_valid, 1'b1);
    check_eq("resp_mem_req", mem_req, 1'b0);
    check_eq("resp_rdata", resp_rdata, exp_q.pop_front());
    @(posedge clk);
    check_eq("resp_one_cycle", resp_valid, 1'b0);
    check_eq("hit_count", hit_count, sat16(m_hits));
    check_eq("miss_count", miss_count, sat16(m_misses));
  endtask

  initial begin
    int nh, cyc, errs;
    logic [31:0] a;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    model_reset();

    repeat (3) @(posedge clk);
    check_eq("rst_req_ready", req_ready, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_hit_count", hit_count, 16'h0);
    check_eq("rst_miss_count", miss_count, 16'h0);
    reset = 1'b1;
    #1 check_eq("rel_ready_before_edge", req_ready, 1'b0);
    @(posedge clk);
    check_eq("rel_ready_after_edge", req_ready, 1'b1);

    // Cold read miss, fill with DEADBEEF, then a read hit.
    do_req(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 2);
    check_eq("dir_miss_count", miss_count, 16'd1);
    do_req(1'b0, 32'h0000_0040, 32'h0, 32'h0, 0);
    check_eq("dir_hit_count", hit_count, 16'd1);

    // Write hit dirties line 0; conflicting read forces write-back then fill.
    do_req(1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0, 0);
    do_req(1'b0, 32'h0000_0240, 32'h0, 32'hCAFE_F00D, 1);
    // Dirty line again, evict with a 5-cycle memory delay on both transfers.
    do_req(1'b1, 32'h0000_0240, 32'h5555_AAAA, 32'h0, 0);
    do_req(1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 5);

    // Stray mem_ack while idle.
    mem_ack = 1'b1;
    @(posedge clk);
    mem_ack = 1'b0;
    check_eq("stray_ready", req_ready, 1'b1);
    check_eq("stray_mem_req", mem_req, 1'b0);
    check_eq("stray_resp", resp_valid, 1'b0);
    check_eq("stray_hits", hit_count, sat16(m_hits));
    check_eq("stray_misses", miss_count, sat16(m_misses));

    // Reset during ALLOCATE: line 0 is clean with another tag, so no write-back.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_1000;
    @(posedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    check_eq("abort_alloc_req", mem_req, 1'b1);
    check_eq("abort_alloc_we", mem_we, 1'b0);
    check_eq("abort_alloc_addr", mem_addr, 32'h0000_1000);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_mem_req", mem_req, 1'b0);
    check_eq("abort_resp", resp_valid, 1'b0);
    check_eq("abort_mem_addr", mem_addr, 32'h0);
    check_eq("abort_ready", req_ready, 1'b0);
    repeat (2) @(posedge clk);
    check_eq("abort_resp_later", resp_valid, 1'b0);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    check_eq("abort_cnt_clear", {hit_count, miss_count}, 32'h0);
    do_req(1'b0, 32'h0000_0040, 32'h0, 32'h7777_1111, 1);
    check_eq("post_reset_miss", miss_count, 16'd1);

    // Random traffic over a small tag set to force conflicts and write-backs.
    for (int k = 0; k < 400; k++) begin
      a = {26'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom, $urandom_range(0, 3));
    end

    // Back-to-back read hits on line 0 until hit_count saturates.
    do_req(1'b0, 32'h0000_0040, 32'h0, 32'h600D_CAFE, 0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0040;
    nh   = 0;
    cyc  = 0;
    errs = 0;
    while (nh < 65540 && cyc < 140000) begin
      @(posedge clk);
      cyc++;
      if (resp_valid) begin
        nh++;
        if (resp_rdata !== m_data[0]) errs++;
      end
    end
    req_valid = 1'b0;
    m_hits += nh;
    check_eq("sat_hits_seen", nh, 65540);
    check_eq("sat_rdata_errs", errs, 0);
    @(posedge clk);
    check_eq("sat_hit_count", hit_count, sat16(m_hits));
    check_eq("sat_hit_ffff", hit_count, 16'hFFFF);
    check_eq("sat_miss_count", miss_count, sat16(m_misses));
    do_req(1'b0, 32'h0000_0040, 32'h0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
